// File: rtl/usb2_ts_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : usb2_ts_packer
// Purpose  : Packs a 188-byte MPEG-TS packet stream into the USB2 endpoint-3
//            IN buffer and commits it once PKTS_PER_XFER packets have been
//            collected, or earlier when the stream goes quiet for
//            FLUSH_TIMEOUT cycles on a packet boundary. Packets that cannot
//            be stored (buffer busy, commit in flight, resync) are counted.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   ep3_ext_clk        in   1   sole clock, rising edge
//   reset              in   1   asynchronous, active-high reset
//   ts_data            in   8   transport stream byte
//   ts_valid           in   1   ts_data valid this cycle (no backpressure)
//   ts_sync            in   1   ts_data is byte 0 (0x47) of a packet
//   buf_in_addr        out  11  buffer write address
//   buf_in_data        out  8   buffer write data
//   buf_in_wren        out  1   buffer write strobe
//   buf_in_ready       in   1   buffer free to fill
//   buf_in_commit      out  1   commit request, held until acknowledged
//   buf_in_commit_len  out  11  committed byte count
//   buf_in_commit_ack  in   1   commit acknowledge
//   drop_cnt           out  16  dropped-packet counter, saturating
//   busy               out  1   high whenever not IDLE
// ----------------------------------------------------------------------------
// PKTS_PER_XFER*188 must not exceed 2047 (11-bit buffer address/length).
// ============================================================================
module usb2_ts_packer #(
   parameter int PKTS_PER_XFER = 5,
   parameter int FLUSH_TIMEOUT = 4096
) (
   input  logic        ep3_ext_clk,
   input  logic        reset,
   input  logic [7:0]  ts_data,
   input  logic        ts_valid,
   input  logic        ts_sync,
   output logic [10:0] buf_in_addr,
   output logic [7:0]  buf_in_data,
   output logic        buf_in_wren,
   input  logic        buf_in_ready,
   output logic        buf_in_commit,
   output logic [10:0] buf_in_commit_len,
   input  logic        buf_in_commit_ack,
   output logic [15:0] drop_cnt,
   output logic        busy
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_PCW = $clog2(PKTS_PER_XFER + 1);
   localparam int c_TW  = $clog2(FLUSH_TIMEOUT + 1);

   localparam logic [c_PCW-1:0] c_PKTS      = c_PCW'(PKTS_PER_XFER);
   localparam logic [c_TW-1:0]  c_TO_LAST   = c_TW'(FLUSH_TIMEOUT - 1);
   localparam logic [7:0]       c_LAST_BYTE = 8'd187;
   localparam logic [10:0]      c_PKT_BYTES = 11'd188;
   localparam logic [15:0]      c_DROP_MAX  = 16'hFFFF;

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_FILL     = 3'd1;
   localparam logic [2:0] c_COMMIT   = 3'd2;
   localparam logic [2:0] c_WAIT_ACK = 3'd3;
   localparam logic [2:0] c_DROP     = 3'd4;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [2:0]       r_state;
   logic [7:0]       r_byte_idx;   // position of the next byte within its packet
   logic [c_PCW-1:0] r_pkt_cnt;    // complete packets held in the buffer
   logic [10:0]      r_wr_ptr;     // address for the next accepted byte
   logic [10:0]      r_pkt_base;   // start address of the packet being filled
   logic [c_TW-1:0]  r_to_cnt;     // idle cycles seen on a packet boundary
   logic [15:0]      r_drop_cnt;

   logic [10:0]      r_wr_addr;
   logic [7:0]       r_wr_data;
   logic             r_wr_en;
   logic             r_commit;
   logic [10:0]      r_commit_len;

   logic             w_sop;        // start-of-packet byte presented
   logic [15:0]      w_drop_next;  // saturating drop increment
   logic [10:0]      w_fill_len;

   assign w_sop       = ts_valid & ts_sync;
   assign w_drop_next = (r_drop_cnt == c_DROP_MAX) ? r_drop_cnt : r_drop_cnt + 16'd1;
   assign w_fill_len  = 11'(r_pkt_cnt) * c_PKT_BYTES;

   // ------------------------------------------------------------------------
   // Main sequencer. Write outputs are registered, so every accepted byte
   // appears on the buffer port exactly one cycle after it was presented.
   // ------------------------------------------------------------------------
   always_ff @(posedge ep3_ext_clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_IDLE;
         r_byte_idx   <= 8'd0;
         r_pkt_cnt    <= '0;
         r_wr_ptr     <= 11'd0;
         r_pkt_base   <= 11'd0;
         r_to_cnt     <= '0;
         r_drop_cnt   <= 16'd0;
         r_wr_addr    <= 11'd0;
         r_wr_data    <= 8'd0;
         r_wr_en      <= 1'b0;
         r_commit     <= 1'b0;
         r_commit_len <= 11'd0;
      end else begin
         // Write strobe is a one-cycle pulse per accepted byte.
         r_wr_en <= 1'b0;

         case (r_state)
            // IDLE and DROP share the same packet-start decision; DROP only
            // differs in that the current packet's bytes are being thrown away.
            c_IDLE, c_DROP: begin
               if (w_sop) begin
                  if (buf_in_ready) begin
                     r_state    <= c_FILL;
                     r_wr_en    <= 1'b1;
                     r_wr_addr  <= 11'd0;
                     r_wr_data  <= ts_data;
                     r_wr_ptr   <= 11'd1;
                     r_pkt_base <= 11'd0;
                     r_byte_idx <= 8'd1;
                     r_to_cnt   <= '0;
                  end else begin
                     r_state    <= c_DROP;
                     r_drop_cnt <= w_drop_next;
                  end
               end
            end

            c_FILL: begin
               if (r_pkt_cnt == c_PKTS) begin
                  // Final byte write is on the port this cycle; raise the
                  // commit on the next one. Sync bytes arriving now are lost.
                  r_state      <= c_COMMIT;
                  r_commit     <= 1'b1;
                  r_commit_len <= w_fill_len;
                  if (w_sop) begin
                     r_drop_cnt <= w_drop_next;
                  end
               end else if (r_byte_idx == 8'd0) begin
                  // On a packet boundary: only a sync byte opens a new packet.
                  if (ts_valid) begin
                     r_to_cnt <= '0;
                     if (ts_sync) begin
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= r_wr_ptr;
                        r_wr_data  <= ts_data;
                        r_pkt_base <= r_wr_ptr;
                        r_wr_ptr   <= r_wr_ptr + 11'd1;
                        r_byte_idx <= 8'd1;
                     end
                  end else if (r_pkt_cnt != '0) begin
                     // Stream has gone quiet with whole packets buffered:
                     // flush them rather than sit on them indefinitely.
                     if (r_to_cnt == c_TO_LAST) begin
                        r_state      <= c_COMMIT;
                        r_commit     <= 1'b1;
                        r_commit_len <= w_fill_len;
                        r_to_cnt     <= '0;
                     end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                     end
                  end
               end else if (ts_valid) begin
                  if (ts_sync) begin
                     // Resync mid-packet: abandon the partial packet and
                     // restart it in place as byte 0 of the new one.
                     r_wr_en    <= 1'b1;
                     r_wr_addr  <= r_pkt_base;
                     r_wr_data  <= ts_data;
                     r_wr_ptr   <= r_pkt_base + 11'd1;
                     r_byte_idx <= 8'd1;
                     r_drop_cnt <= w_drop_next;
                  end else begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= r_wr_ptr;
                     r_wr_data <= ts_data;
                     r_wr_ptr  <= r_wr_ptr + 11'd1;
                     if (r_byte_idx == c_LAST_BYTE) begin
                        r_byte_idx <= 8'd0;
                        r_pkt_cnt  <= r_pkt_cnt + 1'b1;
                     end else begin
                        r_byte_idx <= r_byte_idx + 8'd1;
                     end
                  end
               end
            end

            c_COMMIT: begin
               if (w_sop) begin
                  r_drop_cnt <= w_drop_next;
               end
               if (buf_in_commit_ack) begin
                  r_state  <= c_WAIT_ACK;
                  r_commit <= 1'b0;
               end
            end

            c_WAIT_ACK: begin
               if (w_sop) begin
                  r_drop_cnt <= w_drop_next;
               end
               // Wait for the ack handshake to complete before reusing the
               // buffer from address 0.
               if (!buf_in_commit_ack) begin
                  r_state      <= c_IDLE;
                  r_wr_ptr     <= 11'd0;
                  r_pkt_base   <= 11'd0;
                  r_byte_idx   <= 8'd0;
                  r_pkt_cnt    <= '0;
                  r_to_cnt     <= '0;
                  r_commit_len <= 11'd0;
               end
            end

            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign buf_in_addr       = r_wr_addr;
   assign buf_in_data       = r_wr_data;
   assign buf_in_wren       = r_wr_en;
   assign buf_in_commit     = r_commit;
   assign buf_in_commit_len = r_commit_len;
   assign drop_cnt          = r_drop_cnt;
   assign busy              = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb2_ts_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_usb2_ts_packer
// Purpose  : Directed self-checking bench for usb2_ts_packer. Packet bytes
//            follow a fixed pattern so every buffer location can be predicted.
// Revision : 1.0  initial release
// ============================================================================
module tb_usb2_ts_packer;

   logic        clk;
   logic        reset;
   logic [7:0]  ts_data;
   logic        ts_valid;
   logic        ts_sync;
   logic [10:0] buf_in_addr;
   logic [7:0]  buf_in_data;
   logic        buf_in_wren;
   logic        buf_in_ready;
   logic        buf_in_commit;
   logic [10:0] buf_in_commit_len;
   logic        buf_in_commit_ack;
   logic [15:0] drop_cnt;
   logic        busy;

   usb2_ts_packer #(
      .PKTS_PER_XFER (5),
      .FLUSH_TIMEOUT (4096)
   ) dut (
      .ep3_ext_clk       (clk),
      .reset             (reset),
      .ts_data           (ts_data),
      .ts_valid          (ts_valid),
      .ts_sync           (ts_sync),
      .buf_in_addr       (buf_in_addr),
      .buf_in_data       (buf_in_data),
      .buf_in_wren       (buf_in_wren),
      .buf_in_ready      (buf_in_ready),
      .buf_in_commit     (buf_in_commit),
      .buf_in_commit_len (buf_in_commit_len),
      .buf_in_commit_ack (buf_in_commit_ack),
      .drop_cnt          (drop_cnt),
      .busy              (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Write/commit log, sampled on the falling edge.
   logic [7:0] wmem  [0:2047];
   bit         wflag [0:2047];
   int cyc           = 0;
   int wr_cnt        = 0;
   int dup_cnt       = 0;
   int last_wr_cyc   = 0;
   int first_wr_addr = -1;
   int commit_cyc    = -1;
   int commit_len_seen = 0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (buf_in_wren) begin
         if (first_wr_addr < 0) first_wr_addr = int'(buf_in_addr);
         if (wflag[buf_in_addr]) dup_cnt = dup_cnt + 1;
         wflag[buf_in_addr] = 1'b1;
         wmem[buf_in_addr]  = buf_in_data;
         wr_cnt      = wr_cnt + 1;
         last_wr_cyc = cyc;
      end
      if (buf_in_commit && commit_cyc < 0) begin
         commit_cyc      = cyc;
         commit_len_seen = int'(buf_in_commit_len);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      for (int i = 0; i < 2048; i++) begin
         wflag[i] = 1'b0;
         wmem[i]  = 8'h00;
      end
      wr_cnt        = 0;
      dup_cnt       = 0;
      first_wr_addr = -1;
      commit_cyc    = -1;
   endtask

   task automatic do_reset();
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      ts_data  = 8'h00;
      buf_in_commit_ack = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      clear_log();
   endtask

   function automatic logic [7:0] pat(input int p, input int k);
      logic [7:0] v;
      v = 8'((p * 7 + k) & 255);
      return (k == 0) ? 8'h47 : v;
   endfunction

   task automatic send_pkt(input int p, input int n);
      for (int k = 0; k < n; k++) begin
         ts_data  = pat(p, k);
         ts_sync  = (k == 0);
         ts_valid = 1'b1;
         tick();
      end
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
   endtask

   task automatic idle(input int n);
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      repeat (n) tick();
   endtask

   // Mismatching or unwritten bytes of one whole packet at a base address.
   function automatic int pkt_errs(input int base, input int p);
      int e;
      e = 0;
      for (int k = 0; k < 188; k++) begin
         if (!wflag[base + k] || wmem[base + k] !== pat(p, k)) e = e + 1;
      end
      return e;
   endfunction

   task automatic wait_commit(input string tag, input int budget);
      for (int i = 0; i < budget && commit_cyc < 0; i++) tick();
      chk(tag, 32'(commit_cyc >= 0), 32'd1);
   endtask

   task automatic ack_pulse();
      buf_in_commit_ack = 1'b1;
      tick();
      buf_in_commit_ack = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e;
      int d;
      reset = 1'b1;
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      ts_data  = 8'h00;
      buf_in_ready = 1'b1;
      buf_in_commit_ack = 1'b0;
      clear_log();
      repeat (3) tick();

      // Reset state
      chk("rst_wren",   32'(buf_in_wren), 32'd0);
      chk("rst_addr",   32'(buf_in_addr), 32'd0);
      chk("rst_data",   32'(buf_in_data), 32'd0);
      chk("rst_commit", 32'(buf_in_commit), 32'd0);
      chk("rst_len",    32'(buf_in_commit_len), 32'd0);
      chk("rst_drop",   32'(drop_cnt), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // Five back-to-back packets fill and commit 940 bytes
      do_reset();
      buf_in_ready = 1'b1;
      for (int p = 0; p < 5; p++) send_pkt(p, 188);
      wait_commit("t1_commit_seen", 50);
      e = 0;
      for (int p = 0; p < 5; p++) e = e + pkt_errs(p * 188, p);
      chk("t1_wr_cnt", 32'(wr_cnt), 32'd940);
      chk("t1_dup", 32'(dup_cnt), 32'd0);
      chk("t1_data_errs", 32'(e), 32'd0);
      chk("t1_commit_lat", 32'(commit_cyc - last_wr_cyc), 32'd1);
      chk("t1_len", 32'(commit_len_seen), 32'd940);
      chk("t1_busy", 32'(busy), 32'd1);
      idle(5);
      chk("t1_hold_commit", 32'(buf_in_commit), 32'd1);
      chk("t1_hold_len", 32'(buf_in_commit_len), 32'd940);
      chk("t1_no_wr_commit", 32'(wr_cnt), 32'd940);
      ack_pulse();
      chk("t1_commit_low", 32'(buf_in_commit), 32'd0);
      chk("t1_idle", 32'(busy), 32'd0);

      // Two packets, then a quiet stream flushes 376 bytes
      do_reset();
      send_pkt(20, 188);
      send_pkt(21, 188);
      wait_commit("t2_commit_seen", 4300);
      d = commit_cyc - last_wr_cyc;
      chk("t2_flush_delay", 32'(d >= 4096 && d <= 4098), 32'd1);
      chk("t2_len", 32'(commit_len_seen), 32'd376);
      chk("t2_wr_cnt", 32'(wr_cnt), 32'd376);
      ack_pulse();
      chk("t2_idle", 32'(busy), 32'd0);
      clear_log();
      send_pkt(22, 188);
      idle(2);
      chk("t2_restart_addr", 32'(first_wr_addr), 32'd0);
      chk("t2_restart_wr", 32'(wr_cnt), 32'd188);
      chk("t2_restart_data", 32'(pkt_errs(0, 22)), 32'd0);

      // Resync at byte 100 of the second packet
      do_reset();
      send_pkt(0, 188);
      send_pkt(1, 100);
      send_pkt(11, 188);
      send_pkt(2, 188);
      send_pkt(3, 188);
      send_pkt(4, 188);
      wait_commit("t3_commit_seen", 50);
      e = pkt_errs(0, 0) + pkt_errs(188, 11) + pkt_errs(376, 2)
        + pkt_errs(564, 3) + pkt_errs(752, 4);
      chk("t3_drop", 32'(drop_cnt), 32'd1);
      chk("t3_wr_cnt", 32'(wr_cnt), 32'd1040);
      chk("t3_len", 32'(commit_len_seen), 32'd940);
      chk("t3_data_errs", 32'(e), 32'd0);
      chk("t3_beyond_940", 32'(wflag[940]), 32'd0);
      ack_pulse();

      // Buffer not ready at packet start
      do_reset();
      buf_in_ready = 1'b0;
      send_pkt(30, 188);
      idle(2);
      chk("t4_no_wr", 32'(wr_cnt), 32'd0);
      chk("t4_drop", 32'(drop_cnt), 32'd1);
      chk("t4_busy_drop", 32'(busy), 32'd1);
      buf_in_ready = 1'b1;
      send_pkt(31, 188);
      idle(2);
      chk("t4_first_addr", 32'(first_wr_addr), 32'd0);
      chk("t4_wr_cnt", 32'(wr_cnt), 32'd188);
      chk("t4_data", 32'(pkt_errs(0, 31)), 32'd0);
      chk("t4_drop_after", 32'(drop_cnt), 32'd1);

      // Packets arriving while waiting for the ack to drop
      do_reset();
      for (int p = 40; p < 45; p++) send_pkt(p, 188);
      wait_commit("t5_commit_seen", 50);
      buf_in_commit_ack = 1'b1;
      tick();
      tick();
      chk("t5_commit_low", 32'(buf_in_commit), 32'd0);
      for (int p = 45; p < 48; p++) send_pkt(p, 188);
      idle(2);
      chk("t5_drop", 32'(drop_cnt), 32'd3);
      chk("t5_no_wr", 32'(wr_cnt), 32'd940);
      chk("t5_busy", 32'(busy), 32'd1);
      buf_in_commit_ack = 1'b0;
      tick();
      tick();
      chk("t5_idle", 32'(busy), 32'd0);

      // Asynchronous reset at byte 50 of the third packet
      do_reset();
      send_pkt(50, 188);
      send_pkt(51, 188);
      send_pkt(52, 51);
      chk("t6_wren_pre", 32'(buf_in_wren), 32'd1);
      reset = 1'b1;
      #1;
      chk("t6_wren_async", 32'(buf_in_wren), 32'd0);
      chk("t6_addr_async", 32'(buf_in_addr), 32'd0);
      chk("t6_data_async", 32'(buf_in_data), 32'd0);
      chk("t6_busy_async", 32'(busy), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      clear_log();
      idle(4100);
      chk("t6_no_commit", 32'(commit_cyc >= 0), 32'd0);
      chk("t6_no_wr", 32'(wr_cnt), 32'd0);
      chk("t6_idle", 32'(busy), 32'd0);

      // Drop counter saturation
      do_reset();
      buf_in_ready = 1'b0;
      ts_data  = 8'h47;
      ts_sync  = 1'b1;
      ts_valid = 1'b1;
      repeat (65535) tick();
      ts_valid = 1'b0;
      ts_sync  = 1'b0;
      chk("sat_reach", 32'(drop_cnt), 32'hFFFF);
      send_pkt(60, 1);
      send_pkt(61, 1);
      idle(1);
      chk("sat_hold", 32'(drop_cnt), 32'hFFFF);
      reset = 1'b1;
      #1;
      chk("sat_rst_clear", 32'(drop_cnt), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/usb2_ts_packer.md
USB2_TS_PACKER -- requirements
Module: usb2_ts_packer

Interface
REQ-001 SHALL have parameter PKTS_PER_XFER, default 5, MPEG-TS packets per commit; PKTS_PER_XFER*188 SHALL not exceed 2047.
REQ-002 SHALL have parameter FLUSH_TIMEOUT, default 4096, idle cycles before a partial transfer is committed.
REQ-003 ep3_ext_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ts_data  in  8  transport stream byte.
REQ-006 ts_valid  in  1  ts_data valid this cycle; no backpressure exists.
REQ-007 ts_sync  in  1  qualifies ts_data as byte 0 (0x47) of a packet; meaningful only with ts_valid.
REQ-008 buf_in_addr  out  11  endpoint-3 buffer write address.
REQ-009 buf_in_data  out  8  endpoint-3 buffer write data.
REQ-010 buf_in_wren  out  1  endpoint-3 buffer write strobe.
REQ-011 buf_in_ready  in  1  endpoint-3 buffer free to fill.
REQ-012 buf_in_commit  out  1  commit request.
REQ-013 buf_in_commit_len  out  11  committed byte count.
REQ-014 buf_in_commit_ack  in  1  commit acknowledge.
REQ-015 drop_cnt  out  16  dropped-packet counter, saturating.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 States SHALL be IDLE, FILL, COMMIT, WAIT_ACK, DROP.
REQ-018 Byte index (0..187), packet count, write pointer, timeout counter SHALL be internal registers.
REQ-019 IDLE: ts_valid&ts_sync with buf_in_ready=1 -> FILL, byte written at address 0.
REQ-020 IDLE: ts_valid&ts_sync with buf_in_ready=0 -> DROP, drop_cnt+1.
REQ-021 IDLE: ts_valid without ts_sync SHALL be ignored (no write, no count).
REQ-022 Each accepted byte SHALL be written exactly one cycle after its ts_valid cycle: buf_in_wren=1, buf_in_data=byte, buf_in_addr=write pointer; pointer then increments.
REQ-023 After byte 187, packet count SHALL increment and byte index SHALL return to 0.
REQ-024 FILL with byte index 0: next byte requires ts_sync; a non-sync valid byte SHALL be ignored.
REQ-025 FILL with byte index !=0 and ts_valid&ts_sync (resync): write pointer SHALL rewind to packet start, drop_cnt+1, the byte SHALL be written as byte 0 of the new packet.
REQ-026 Packet count reaching PKTS_PER_XFER SHALL move to COMMIT on the cycle after the final byte write.
REQ-027 FILL, byte index 0, packet count>0: timeout counter SHALL count cycles without ts_valid and reset on ts_valid; reaching FLUSH_TIMEOUT SHALL move to COMMIT.
REQ-028 COMMIT: buf_in_commit=1, buf_in_commit_len=packet count*188, both held until buf_in_commit_ack=1, then WAIT_ACK.
REQ-029 WAIT_ACK: buf_in_commit=0; on buf_in_commit_ack=0 -> IDLE with pointer, byte index, packet count cleared.
REQ-030 COMMIT/WAIT_ACK: every ts_valid&ts_sync SHALL increment drop_cnt; no writes occur.
REQ-031 DROP: bytes discarded; next ts_valid&ts_sync evaluated as in IDLE (buffer ready -> FILL, else stay in DROP with drop_cnt+1).
REQ-032 drop_cnt SHALL saturate at 0xFFFF, never wrap.
REQ-033 buf_in_wren SHALL never assert outside FILL or its entry cycle; write pointer SHALL never exceed PKTS_PER_XFER*188-1.

Reset
REQ-034 reset=1 SHALL force IDLE immediately, all outputs 0, drop_cnt=0, all internal counters 0, including mid-FILL or mid-COMMIT; no commit is issued for partial data.

Verification
REQ-035 Five back-to-back 188-byte packets, buf_in_ready=1 -> 940 writes addr 0..939, buf_in_commit=1 with len 940 one cycle after last write, held until ack.
REQ-036 Two packets then 4096 idle cycles -> commit with len 376; ack pulse -> IDLE, next packet written from address 0.
REQ-037 ts_sync at byte index 100 of packet 2 -> pointer rewinds to 188, drop_cnt=1, five complete packets still commit len 940.
REQ-038 buf_in_ready=0 at packet start -> no writes, drop_cnt=1, DROP; ready=1 at next sync -> FILL at address 0.
REQ-039 Packet starts during WAIT_ACK -> drop_cnt increments per sync, buf_in_wren stays 0.
REQ-040 reset pulse at byte 50 of packet 3 -> outputs 0 immediately, no commit; drop_cnt forced to 0xFFFF path then one more drop -> stays 0xFFFF.
